// File: rtl/local_mac_seq.sv
// -----------------------------------------------------------------------------
// local_mac_seq
//
// Sequences one combinational local_mac array through a multi-tile dot product.
// A job fetches num_tiles tiles one per tile_vld beat, feeds the running sum
// back into the MAC addend (C_in, saturated to CIN_W bits) and, on the last
// tile only, optionally enables zero-point subtraction (op_sel=1, D_in=zp_val).
// The final ACC_W-bit result is held on a valid/ready output port.
//
// Handshake rules:
//   out_valid/out_ready : out_data is held stable while out_valid is high; a
//                         transfer happens on any clock where both are high,
//                         and done pulses in that same cycle.
//   tile_req/tile_vld   : tile_req is high in RUN for tile_addr; a tile is
//                         consumed on every clock where tile_vld is high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_tiles,   job request and its parameters (sampled in IDLE)
//   zp_en, zp_val
//   abort               synchronous job cancel
//   tile_req, tile_addr operand fetch request and tile index
//   tile_vld            operands for tile_addr are on the MAC inputs
//   mac_result          local_mac result_out (combinational)
//   mac_c_in, mac_d_in, local_mac C_in / D_in / op_sel
//   mac_op_sel
//   out_data, out_valid, out_ready   result port
//   busy, done, sat_flag status
//   dbg_state           current FSM state (IDLE=0, RUN=1, OUT=2)
// -----------------------------------------------------------------------------
module local_mac_seq #(
   parameter int TILE_W = 8,
   parameter int ACC_W  = 14,
   parameter int CIN_W  = 12   // must be smaller than ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic              zp_en,
   input  logic [CIN_W-1:0]  zp_val,
   input  logic              abort,
   output logic              tile_req,
   output logic [TILE_W-1:0] tile_addr,
   input  logic              tile_vld,
   input  logic [ACC_W-1:0]  mac_result,
   output logic [CIN_W-1:0]  mac_c_in,
   output logic [CIN_W-1:0]  mac_d_in,
   output logic              mac_op_sel,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              sat_flag,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] C_CIN_MAX_ACC = ACC_W'((1 << CIN_W) - 1);
   localparam logic [CIN_W-1:0] C_CIN_MAX     = {CIN_W{1'b1}};

   state_t              r_state;
   state_t              w_next;
   logic [TILE_W-1:0]   r_num;
   logic                r_zp_en;
   logic [CIN_W-1:0]    r_zp_val;
   logic [ACC_W-1:0]    r_acc;
   logic [TILE_W-1:0]   r_addr;
   logic [ACC_W-1:0]    r_out_data;
   logic                r_out_valid;
   logic                r_sat;

   logic                w_run;
   logic                w_last;
   logic                w_clamp;
   logic                w_zp_op;
   logic                w_hs;
   logic                w_accept;

   // Feedback clamp: the accumulator is wider than the MAC addend port.
   assign w_run    = (r_state == S_RUN);
   assign w_last   = (r_addr == (r_num - TILE_W'(1)));
   assign w_clamp  = (r_acc > C_CIN_MAX_ACC);
   assign w_zp_op  = w_last & r_zp_en;
   assign w_hs     = (r_state == S_OUT) & r_out_valid & out_ready;
   assign w_accept = start & (num_tiles != '0);

   // Next state and outputs
   always_comb begin
      w_next     = r_state;
      tile_req   = 1'b0;
      mac_c_in   = '0;
      mac_d_in   = '0;
      mac_op_sel = 1'b0;
      done       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_RUN;
         end
         S_RUN: begin
            tile_req   = 1'b1;
            mac_c_in   = w_clamp ? C_CIN_MAX : r_acc[CIN_W-1:0];
            mac_op_sel = w_zp_op;
            mac_d_in   = w_zp_op ? r_zp_val : '0;
            if (tile_vld && w_last) w_next = S_OUT;
         end
         S_OUT: begin
            if (w_hs) begin
               w_next = S_IDLE;
               done   = ~abort & ~rst;
            end
         end
         default: w_next = S_IDLE;
      endcase

      // Cancel wins over every in-state transition.
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_num       <= '0;
         r_zp_en     <= 1'b0;
         r_zp_val    <= '0;
         r_acc       <= '0;
         r_addr      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (abort) begin
            // out_data and sat_flag are deliberately left as they were.
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_num    <= num_tiles;
                     r_zp_en  <= zp_en;
                     r_zp_val <= zp_val;
                     r_acc    <= '0;
                     r_addr   <= '0;
                     r_sat    <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (tile_vld) begin
                     if (w_clamp) r_sat <= 1'b1;
                     if (w_last) begin
                        r_out_data  <= mac_result;
                        r_out_valid <= 1'b1;
                     end else begin
                        r_acc  <= mac_result;
                        r_addr <= r_addr + TILE_W'(1);
                     end
                  end
               end
               S_OUT: begin
                  if (w_hs) r_out_valid <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign tile_addr = r_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != S_IDLE);
   assign sat_flag  = r_sat;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_local_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_local_mac_seq
//
// Bench for local_mac_seq. The bench plays the local_mac array: per tile it
// holds a "product sum" value w_arr[t], and the MAC result is
// (C_in + w_arr[tile_addr] - (op_sel ? D_in : 0)) mod 2^14.
// A reference model computes, from the job parameters and w_arr, the C_in /
// op_sel / D_in each tile must see, the final result and the sticky clamp flag.
// Expected results go to exp_q when a job is issued; a negedge monitor pops
// and compares whenever the output handshake occurs.
// -----------------------------------------------------------------------------
module tb_local_mac_seq;

   localparam int TILE_W = 8;
   localparam int ACC_W  = 14;
   localparam int CIN_W  = 12;
   localparam int CMAX   = (1 << CIN_W) - 1;
   localparam int AMASK  = (1 << ACC_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start = 1'b0;
   logic [TILE_W-1:0] num_tiles = '0;
   logic              zp_en = 1'b0;
   logic [CIN_W-1:0]  zp_val = '0;
   logic              abort = 1'b0;
   logic              tile_req;
   logic [TILE_W-1:0] tile_addr;
   logic              tile_vld = 1'b0;
   logic [ACC_W-1:0]  mac_result;
   logic [CIN_W-1:0]  mac_c_in;
   logic [CIN_W-1:0]  mac_d_in;
   logic              mac_op_sel;
   logic [ACC_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              done;
   logic              sat_flag;
   logic [1:0]        dbg_state;

   local_mac_seq #(.TILE_W(TILE_W), .ACC_W(ACC_W), .CIN_W(CIN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
      .zp_en(zp_en), .zp_val(zp_val), .abort(abort),
      .tile_req(tile_req), .tile_addr(tile_addr), .tile_vld(tile_vld),
      .mac_result(mac_result), .mac_c_in(mac_c_in), .mac_d_in(mac_d_in),
      .mac_op_sel(mac_op_sel), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .sat_flag(sat_flag),
      .dbg_state(dbg_state)
   );

   // ---------------- local_mac stand-in ----------------
   int w_arr [256];
   assign mac_result = ACC_W'(int'(mac_c_in) + w_arr[tile_addr]
                              - (mac_op_sel ? int'(mac_d_in) : 0));

   // ---------------- scoreboard ----------------
   logic [ACC_W:0] exp_q[$];   // {sat, data}
   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int jobs_acked = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: handshake drives the scoreboard, done must match handshake.
   always @(negedge clk) begin
      logic [ACC_W:0] e;
      logic           hs;
      hs = !rst && !abort && out_valid && out_ready;
      if (done) done_cnt++;
      if (done || hs) chk("done_vs_handshake", done, hs);
      if (hs) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d with empty expected queue", out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e[ACC_W-1:0]);
            chk("sat_flag_at_out", sat_flag, e[ACC_W]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_w(input int n, input int maxv);
      for (int t = 0; t < n; t++) w_arr[t] = $urandom_range(0, maxv);
   endtask

   // mode: 0 = tile_vld always high, 1..99 = gap percentage, -1 = pattern 1-0-0-1-1
   // rdy_dly < 0: leave the job sitting in OUT (no handshake)
   task automatic run_job(input int n, input bit zen, input int zv,
                          input int mode, input int rdy_dly);
      int cin_e [256];
      bit op_e [256];
      int d_e [256];
      int acc, k, cyc, res;
      bit sat;
      logic [4:0] pat;
      pat = 5'b11001;

      // reference model
      acc = 0;
      sat = 1'b0;
      for (int t = 0; t < n; t++) begin
         if (acc > CMAX) sat = 1'b1;
         cin_e[t] = (acc > CMAX) ? CMAX : acc;
         op_e[t]  = (t == n - 1) && zen;
         d_e[t]   = op_e[t] ? zv : 0;
         acc      = (cin_e[t] + w_arr[t] - d_e[t]) & AMASK;
      end
      res = acc;
      if (rdy_dly >= 0) exp_q.push_back({sat, ACC_W'(res)});

      start     = 1'b1;
      num_tiles = TILE_W'(n);
      zp_en     = zen;
      zp_val    = CIN_W'(zv);
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("sat_clear_on_start", sat_flag, 0);
      chk("addr_zero_on_start", tile_addr, 0);

      k = 0;
      cyc = 0;
      while (!out_valid && cyc < 1000) begin
         if (mode < 0) tile_vld = pat[cyc % 5];
         else          tile_vld = ($urandom_range(0, 99) >= mode);
         #1;
         chk("tile_req_run", tile_req, 1);
         if (tile_vld) begin
            chk("tile_addr", tile_addr, k);
            chk("mac_c_in", mac_c_in, cin_e[k]);
            chk("mac_op_sel", mac_op_sel, op_e[k]);
            chk("mac_d_in", mac_d_in, d_e[k]);
            k++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      tile_vld = 1'b0;
      if (!out_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL out_valid_timeout: no out_valid after %0d cycles", cyc);
         return;
      end
      chk("tiles_consumed", k, n);
      if (mode == 0) chk("latency", cyc, n);
      chk("tile_req_out", tile_req, 0);
      chk("sat_in_out", sat_flag, sat);
      if (rdy_dly < 0) return;

      // backpressure: hold, stay busy, ignore start
      for (int i = 0; i < rdy_dly; i++) begin
         start     = 1'b1;
         num_tiles = 8'd1;
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, res);
         chk("bp_busy", busy, 1);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      jobs_acked++;
      chk("idle_after_hs", busy, 0);
      chk("valid_low_after_hs", out_valid, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int sat_before;
      repeat (3) tick();
      chk("rst_tile_req", tile_req, 0);
      chk("rst_tile_addr", tile_addr, 0);
      chk("rst_c_in", mac_c_in, 0);
      chk("rst_d_in", mac_d_in, 0);
      chk("rst_op_sel", mac_op_sel, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sat", sat_flag, 0);
      rst = 1'b0;
      tick();

      // single tile, result 100, immediate accept
      w_arr[0] = 100;
      run_job(1, 0, 0, 0, 0);
      chk("single_out_data_held", out_data, 100);

      // three tiles with zero point on the last one: 0,200,400 -> 595
      for (int t = 0; t < 3; t++) w_arr[t] = 200;
      run_job(3, 1, 5, 0, 1);

      // clamp: first result 5000 saturates the feedback to 4095
      w_arr[0] = 5000;
      w_arr[1] = 10;
      run_job(2, 0, 0, 0, 0);
      chk("sat_sticky_idle", sat_flag, 1);

      // backpressure for 10 cycles with start spam
      fill_w(2, 3000);
      run_job(2, 1, 77, 0, 10);

      // gapped valid, same operands as a gap-free run
      for (int t = 0; t < 3; t++) w_arr[t] = 300 + t;
      run_job(3, 0, 0, -1, 0);
      run_job(3, 0, 0, 0, 0);

      // abort in RUN at tile 1 of 4
      fill_w(4, 1000);
      start = 1'b1;
      num_tiles = 8'd4;
      tick();
      start = 1'b0;
      tile_vld = 1'b1;
      tick();
      tile_vld = 1'b0;
      chk("abort_pre_addr", tile_addr, 1);
      sat_before = int'(sat_flag);
      abort = 1'b1;
      #1;
      chk("abort_no_done", done, 0);
      tick();
      abort = 1'b0;
      chk("abort_idle", busy, 0);
      chk("abort_tile_req", tile_req, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_sat_kept", sat_flag, sat_before);

      // tile_vld outside RUN and start with zero tiles are both ignored
      tile_vld = 1'b1;
      start = 1'b1;
      num_tiles = 8'd0;
      tick();
      tick();
      start = 1'b0;
      tile_vld = 1'b0;
      chk("zero_start_idle", busy, 0);
      chk("zero_start_state", dbg_state, 0);
      chk("idle_vld_addr", tile_addr, 1);

      // reset while sitting in OUT
      fill_w(2, 2000);
      run_job(2, 0, 0, 0, -1);
      rst = 1'b1;
      tick();
      chk("rstout_valid", out_valid, 0);
      chk("rstout_data", out_data, 0);
      chk("rstout_busy", busy, 0);
      chk("rstout_done", done, 0);
      chk("rstout_tile_req", tile_req, 0);
      chk("rstout_addr", tile_addr, 0);
      chk("rstout_sat", sat_flag, 0);
      rst = 1'b0;
      tick();

      // randomized jobs
      for (int j = 0; j < 30; j++) begin
         int n;
         n = $urandom_range(1, 6);
         fill_w(n, ($urandom_range(0, 3) == 0) ? 6000 : 1500);
         run_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, CMAX),
                 $urandom_range(0, 1) ? 0 : $urandom_range(1, 60),
                 $urandom_range(0, 3));
      end

      repeat (3) tick();
      chk("done_count", done_cnt, jobs_acked);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
